// File: rtl/reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_seq
// Purpose  : Register file plus ALU execution core with a shift-add multiplier.
//            Optional macro REG_ALU_SEQ_ZERO_REG_EN makes register 0 read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module reg_alu_seq #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [ADDR_W-1:0] cmd_wa,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_data,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_NOT = 3'b101;
    localparam logic [2:0] c_OP_SHL = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

`ifdef REG_ALU_SEQ_ZERO_REG_EN
    localparam bit c_ZERO_REG = 1'b1;
`else
    localparam bit c_ZERO_REG = 1'b0;
`endif

    generate
        if (NREGS != (1 << ADDR_W)) begin : g_nregs_check
            $error("reg_alu_seq: NREGS must equal 2**ADDR_W");
        end
        if (WIDTH < 4) begin : g_width_check
            $error("reg_alu_seq: WIDTH must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_regs [NREGS];
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH-1:0]     r_acc;
    logic [2:0]           r_op;
    logic [ADDR_W-1:0]    r_wa;
    logic [c_CNT_W-1:0]   r_count;

    logic [WIDTH-1:0]     w_rd_a;
    logic [WIDTH-1:0]     w_rd_b;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_mul_acc;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_c;
    logic                 w_wb;
    logic                 w_wb_we;
    logic                 w_ld_we;

    assign w_rd_a   = (c_ZERO_REG && cmd_ra == '0)   ? '0 : r_regs[cmd_ra];
    assign w_rd_b   = (c_ZERO_REG && cmd_rb == '0)   ? '0 : r_regs[cmd_rb];
    assign dbg_data = (c_ZERO_REG && dbg_addr == '0) ? '0 : r_regs[dbg_addr];

    // One shift-add step; on the last MUL step this is also the final product.
    assign w_mul_acc = r_opb[0] ? (r_acc + r_opa) : r_acc;

    always_comb begin
        w_sum     = {1'b0, r_opa}
                  + {1'b0, (r_op == c_OP_SUB) ? ~r_opb : r_opb}
                  + {{WIDTH{1'b0}}, (r_op == c_OP_SUB)};
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (r_op)
            c_OP_ADD, c_OP_SUB: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            c_OP_AND: w_alu_res = r_opa & r_opb;
            c_OP_OR:  w_alu_res = r_opa | r_opb;
            c_OP_XOR: w_alu_res = r_opa ^ r_opb;
            c_OP_NOT: w_alu_res = ~r_opa;
            c_OP_SHL: begin
                w_alu_res = {r_opa[WIDTH-2:0], 1'b0};
                w_alu_c   = r_opa[WIDTH-1];
            end
            default:  w_alu_res = w_mul_acc;
        endcase
    end

    assign w_wb    = (r_state == S_EXEC)
                   || ((r_state == S_MUL) && (r_count == c_CNT_W'(1)));
    assign w_wb_we = w_wb && !(c_ZERO_REG && r_wa == '0);
    // A load colliding with a writeback to the same register loses.
    assign w_ld_we = ld_en && !(w_wb && (ld_addr == r_wa))
                   && !(c_ZERO_REG && ld_addr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_ld_we) begin
                r_regs[ld_addr] <= ld_data;
            end
            if (w_wb_we) begin
                r_regs[r_wa] <= w_alu_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_op      <= '0;
            r_wa      <= '0;
            r_count   <= '0;
        end else begin
            done <= 1'b0;
            // Flags and result follow the computed value even when register 0 discards it.
            if (w_wb) begin
                result <= w_alu_res;
                flag_c <= w_alu_c;
                flag_z <= (w_alu_res == '0);
                flag_n <= w_alu_res[WIDTH-1];
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_opa     <= w_rd_a;
                        r_opb     <= w_rd_b;
                        r_op      <= cmd_op;
                        r_wa      <= cmd_wa;
                        r_acc     <= '0;
                        r_count   <= c_CNT_W'(WIDTH);
                        cmd_ready <= 1'b0;
                        r_state   <= (cmd_op == c_OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_MUL: begin
                    r_acc   <= w_mul_acc;
                    r_opa   <= r_opa << 1;
                    r_opb   <= r_opb >> 1;
                    r_count <= r_count - c_CNT_W'(1);
                    if (r_count == c_CNT_W'(1)) begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_alu_seq
// Purpose  : Scoreboard bench for reg_alu_seq against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_alu_seq;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;
    localparam longint MAXV = 65536;

`ifdef REG_ALU_SEQ_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_ra;
    logic [ADDR_W-1:0] cmd_rb;
    logic [ADDR_W-1:0] cmd_wa;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [WIDTH-1:0]  ld_data;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              flag_c;
    logic              flag_z;
    logic              flag_n;
    logic [ADDR_W-1:0] dbg_addr;
    logic [WIDTH-1:0]  dbg_data;

    reg_alu_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_wa(cmd_wa),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .done(done), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
        logic             n;
        int               due;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] m_regs [NREGS];
    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] m_rd(input int a);
        return (ZERO_REG && a == 0) ? '0 : m_regs[a];
    endfunction

    function automatic void m_wr(input int a, input logic [WIDTH-1:0] v);
        if (!(ZERO_REG && a == 0)) m_regs[a] = v;
    endfunction

    // Reference ALU in plain modular arithmetic.
    function automatic exp_t m_alu(input int op, input longint a, input longint b);
        exp_t   e;
        longint r;
        e.c = 1'b0;
        case (op)
            0: begin r = a + b; e.c = (r >= MAXV); end
            1: begin r = a - b; e.c = (a >= b); if (r < 0) r = r + MAXV; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (MAXV - 1) - a;
            6: begin r = a * 2; e.c = (a >= MAXV / 2); end
            default: r = a * b;
        endcase
        r     = r % MAXV;
        e.res = r[WIDTH-1:0];
        e.z   = (r == 0);
        e.n   = (r >= MAXV / 2);
        e.due = 0;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin : pop_blk
                exp_t e;
                e = sb.pop_front();
                chk("result",     result, e.res);
                chk("flag_c",     flag_c, e.c);
                chk("flag_z",     flag_z, e.z);
                chk("flag_n",     flag_n, e.n);
                chk("done_cycle", cyc,    e.due);
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 64) chk("cmd_ready_timeout", cmd_ready, 1);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic load(input int a, input logic [WIDTH-1:0] d);
        ld_en = 1'b1; ld_addr = ADDR_W'(a); ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        m_wr(a, d);
    endtask

    task automatic issue(input int op, input int ra, input int rb, input int wa,
                         input bit with_ld, input int la, input logic [WIDTH-1:0] ld,
                         input bit expect_done, output int t);
        exp_t e;
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'(op);
        cmd_ra = ADDR_W'(ra); cmd_rb = ADDR_W'(rb); cmd_wa = ADDR_W'(wa);
        ld_en = with_ld; ld_addr = ADDR_W'(la); ld_data = ld;
        @(posedge clk); #1;
        t = cyc;
        cmd_valid = 1'b0; ld_en = 1'b0;
        e = m_alu(op, m_rd(ra), m_rd(rb));
        e.due = t + ((op == 7) ? WIDTH : 1);
        if (with_ld) m_wr(la, ld);
        if (expect_done) begin
            sb.push_back(e);
            m_wr(wa, e.res);
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = ADDR_W'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), dbg_data, m_rd(i));
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        sb.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int busy;
        int nd;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_wa = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        @(posedge clk); #1;
        do_reset();
        chk("rst_ready",  cmd_ready, 1);
        chk("rst_done",   done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags",  {flag_c, flag_z, flag_n}, 0);
        sweep("rst");

        load(1, 16'h0003); load(2, 16'h0005);
        issue(0, 1, 2, 3, 0, 0, '0, 1, t);
        drain();
        chk("add_r3_result", result, 16'h0008);
        sweep("add");

        load(1, 16'hFFFF); load(2, 16'h0001);
        issue(0, 1, 2, 4, 0, 0, '0, 1, t);
        drain();
        chk("add_wrap_result", result, 16'h0000);
        chk("add_wrap_cz", {flag_c, flag_z}, 2'b11);
        issue(1, 2, 1, 5, 0, 0, '0, 1, t);
        drain();
        chk("sub_result", result, 16'h0002);
        chk("sub_borrow_c", flag_c, 0);
        sweep("sub");

        // MUL busy window with an ignored command pulse in the middle.
        load(1, 16'h0123); load(2, 16'h0045);
        issue(7, 1, 2, 6, 0, 0, '0, 1, t);
        busy = 0;
        for (int k = 0; k < 40 && !cmd_ready; k++) begin
            busy++;
            if (k == 5) begin
                cmd_valid = 1'b1; cmd_op = 3'b000; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_wa = 3'd7;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("mul_busy_cycles", busy, WIDTH + 1);
        chk("mul_result", result, 16'h4E6F);
        drain();
        sweep("mul");

        // Load on the MUL writeback edge: same register, then a different one.
        load(6, 16'h1111);
        issue(7, 1, 2, 6, 0, 0, '0, 1, t);
        repeat (WIDTH - 1) begin @(posedge clk); #1; end
        ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'hAAAA;
        @(posedge clk); #1;
        ld_en = 1'b0;
        drain();
        sweep("coll_same");
        load(6, 16'h1111);
        issue(7, 1, 2, 6, 0, 0, '0, 1, t);
        repeat (WIDTH - 1) begin @(posedge clk); #1; end
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'hAAAA;
        @(posedge clk); #1;
        ld_en = 1'b0;
        m_wr(7, 16'hAAAA);
        drain();
        sweep("coll_diff");

        // Load on the handshake edge to the source register; operands are pre-load.
        load(1, 16'h0005);
        issue(0, 1, 1, 2, 1, 1, 16'h7777, 1, t);
        drain();
        chk("hs_load_result", result, 16'h000A);
        sweep("hs_load");

        // Reset part-way through a MUL.
        issue(7, 1, 2, 6, 0, 0, '0, 0, t);
        repeat (4) begin @(posedge clk); #1; end
        nd = n_done;
        do_reset();
        chk("rstmul_ready",  cmd_ready, 1);
        chk("rstmul_result", result, 0);
        chk("rstmul_flags",  {flag_c, flag_z, flag_n}, 0);
        sweep("rstmul");
        repeat (25) begin @(posedge clk); #1; end
        chk("rstmul_no_done", n_done, nd);

`ifdef REG_ALU_SEQ_ZERO_REG_EN
        load(0, 16'h1234); load(1, 16'h0003);
        issue(0, 0, 1, 0, 0, 0, '0, 1, t);
        drain();
        chk("zero_reg_result", result, 16'h0003);
        sweep("zero_reg");
`endif

        for (int i = 0; i < NREGS; i++) load(i, 16'($urandom));
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) load($urandom_range(0, NREGS - 1), 16'($urandom));
            issue($urandom_range(0, 7), $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                  $urandom_range(0, NREGS - 1), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, NREGS - 1), 16'($urandom), 1, t);
            drain();
            sweep("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
- Parametrised sequential datapath built from a register file and an ALU.
- Contains NREGS registers of WIDTH bits, one external load port, and one command port.
- Each accepted command reads two source registers, executes one ALU op and writes the result back to a destination register.
- MUL is a multi-cycle shift-add op. All other ops are single-cycle. Sits under the lab CPU control unit as its execution core.

Parameters:
- WIDTH, 16, datapath and register width in bits (>=4).
- ADDR_W, 3, register address width.
- NREGS, 8, register count. NREGS must equal 2**ADDR_W; elaboration error otherwise.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  3  opcode
- cmd_ra  in  ADDR_W  source A register
- cmd_rb  in  ADDR_W  source B register
- cmd_wa  in  ADDR_W  destination register
- ld_en  in  1  external register write
- ld_addr  in  ADDR_W  external write address
- ld_data  in  WIDTH  external write data
- done  out  1  one-cycle pulse: command complete
- result  out  WIDTH  result of last command; held until the next done
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- flag_n  out  1  negative flag
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  WIDTH  combinational read of register dbg_addr

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - all registers cleared to 0; FSM goes to IDLE
  - done=0, result=0, flags=0, cmd_ready=1 in the following cycle
  - reset mid-MUL abandons the op with no writeback and no done
- Opcodes (all arithmetic modulo 2**WIDTH):
  - 000 ADD: A+B; C = carry-out
  - 001 SUB: A+~B+1; C = carry-out (1 = no borrow)
  - 010 AND; 011 OR; 100 XOR; 101 NOT A
  - 110 SHL: A<<1; C = A[WIDTH-1]
  - 111 MUL: low WIDTH bits of A*B; C=0
  - Logic ops force C=0.
  - Z = (result==0); N = result[WIDTH-1]. Flags update only at writeback.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE: cmd_ready=1. Handshake occurs on the edge where cmd_valid & cmd_ready; on that edge the block latches opA=reg[ra], opB=reg[rb], op and wa. It goes to MUL if op=111 (count=WIDTH, acc=0), else to EXEC.
  - EXEC: compute; at the end-of-cycle edge write reg[wa], result and flags; go to DONE.
  - MUL: each cycle, if opB[0] then acc+=opA; opA<<=1; opB>>=1; count-=1. On the step where count=1, write the final acc to reg[wa], result and flags; go to DONE. MUL occupies exactly WIDTH cycles.
  - DONE: done=1 for one cycle; cmd_ready=0; next state IDLE.
- Latency, with the handshake at edge t:
  - non-MUL: done is high in cycle t+2, and a new command can be accepted at edge t+3
  - MUL: done is high in cycle t+WIDTH+1
- cmd_valid while cmd_ready=0 is ignored; the command is neither queued nor acknowledged.
- ld_en is honoured in every state:
  - same edge as an ALU writeback to the same address: the ALU result wins and the load is dropped
  - same edge as an ALU writeback to a different address: both writes occur
  - ld_en on the handshake edge targeting ra/rb: the latched operand is the pre-load value
- ra, rb and wa may be equal (e.g. r1 = r1 + r1) and must behave correctly.
- dbg_data is combinational and shows the register value after the last edge.

Optional Feature:
- Macro: REG_ALU_SEQ_ZERO_REG_EN.
- Defined: register 0 always reads 0 on operands and dbg_data. Both ALU writebacks and loads to address 0 are discarded. Flags and result still update from the computed value.
- Undefined: register 0 is an ordinary register.

Test Plan (WIDTH=16):
- Reset, load r1=0x0003 and r2=0x0005, then ADD ra=1 rb=2 wa=3 -> done 2 cycles after handshake; r3=0x0008; C=0 Z=0 N=0.
- r1=0xFFFF, r2=0x0001: ADD wa=4 -> r4=0x0000, C=1, Z=1. Then SUB r2-r1 wa=5 -> r5=0x0002, C=0.
- r1=0x0123, r2=0x0045: MUL wa=6 -> cmd_ready low for 17 cycles; done in cycle t+17; r6=0x4E6F. A cmd_valid pulse mid-MUL is ignored.
- During a MUL writing r6, assert ld_en r6=0xAAAA on the writeback edge -> r6 holds the MUL result. Repeat with ld_addr=7 -> r6 holds the MUL result and r7=0xAAAA.
- Assert reset 5 cycles into a MUL -> no done pulse; all registers, flags and result = 0; cmd_ready=1 next cycle.
- With REG_ALU_SEQ_ZERO_REG_EN defined: load r0=0x1234 then ADD r0+r1(0x0003) wa=0 -> dbg_data(r0)=0x0000; result=0x0003.
